// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and strobe sequencer for the shared MAR/memory/MDR port (IF vs LS).
// Optional WAIT timeout abort is compiled in with `define MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_if,
  input  logic req_ls,
  input  logic ls_rw,
  input  logic MFC,
  output logic gnt_if,
  output logic gnt_ls,
  output logic done_if,
  output logic done_ls,
  output logic addr_sel,
  output logic MAR_write,
  output logic MAR_mem_read,
  output logic MEM_RW,
  output logic MEM_EN,
  output logic MDR_mem_write,
  output logic MDR_write,
  output logic MDR_read,
  output logic busy,
  output logic err
);

  // Handshake: a requester raises req_* and holds it until its done_* pulse;
  // gnt_* marks ownership from ADDR through DONE. MFC is active low.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    ACCESS  = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255 || TIMEOUT >= (2 ** CNT_W)) begin : g_bad_cfg
    $error("mem_port_arbiter: TIMEOUT out of range for CNT_W");
  end

  state_t state;
  state_t state_nxt;

  logic gnt_ls_q;   // owner of the current transaction: 0 = IF, 1 = LS
  logic rw_q;       // 1 = read, 0 = write
  logic last_ls_q;  // most recent grant went to LS
  logic grant_ls;
  logic do_grant;
  logic timeout_hit;
  logic aborted;

  // Tie-break favours whichever requester was not served last.
  assign grant_ls = req_ls && (!req_if || !last_ls_q);
  assign do_grant = (state == IDLE) && (req_if || req_ls);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt_ls_q  <= 1'b0;
      rw_q      <= 1'b1;
      last_ls_q <= 1'b1;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        gnt_ls_q  <= grant_ls;
        rw_q      <= grant_ls ? ls_rw : 1'b1;
        last_ls_q <= grant_ls;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             to_q;

  // Fires on the TIMEOUT-th WAIT cycle while memory is still busy.
  assign timeout_hit = MFC && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign aborted     = to_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (state == WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
      if ((state == WAIT) && timeout_hit) begin
        to_q <= 1'b1;
      end else if (state == DONE) begin
        to_q <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign aborted     = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    addr_sel      = 1'b0;
    MAR_write     = 1'b0;
    MAR_mem_read  = 1'b0;
    MEM_RW        = 1'b0;
    MEM_EN        = 1'b0;
    MDR_mem_write = 1'b0;
    MDR_write     = 1'b0;
    MDR_read      = 1'b0;
    done_if       = 1'b0;
    done_ls       = 1'b0;
    err           = 1'b0;
    unique case (state)
      IDLE: begin
        if (do_grant) state_nxt = ADDR;
      end
      ADDR: begin
        MAR_write = 1'b1;
        addr_sel  = gnt_ls_q;
        MDR_write = !rw_q;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        MAR_mem_read = 1'b1;
        MEM_EN       = 1'b1;
        MEM_RW       = rw_q;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (!MFC) begin
          state_nxt = rw_q ? CAPTURE : DONE;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      CAPTURE: begin
        MDR_mem_write = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        done_if   = !gnt_ls_q;
        done_ls   = gnt_ls_q;
        MDR_read  = rw_q && !aborted;
        err       = aborted;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign gnt_if = busy && !gnt_ls_q;
  assign gnt_ls = busy && gnt_ls_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter (TIMEOUT = 4).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic req_if, req_ls, ls_rw, MFC;
  logic gnt_if, gnt_ls, done_if, done_ls, addr_sel, MAR_write, MAR_mem_read;
  logic MEM_RW, MEM_EN, MDR_mem_write, MDR_write, MDR_read, busy, err;
  logic [13:0] all_out;

  int total = 0;
  int bad   = 0;

  // Expected transaction: {ls, rw, err, latency[7:0]} in grant order.
  logic [10:0] exp_q[$];
  int          mfc_q[$];
  bit          lsrw_q[$];

  int if_left = 0;
  int ls_left = 0;
  bit drop_ls = 0;
  bit ls_dropped = 0;
  bit last_ls = 1;
  int rem = -1;

  mem_port_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_if(req_if), .req_ls(req_ls), .ls_rw(ls_rw), .MFC(MFC),
    .gnt_if(gnt_if), .gnt_ls(gnt_ls), .done_if(done_if), .done_ls(done_ls),
    .addr_sel(addr_sel), .MAR_write(MAR_write), .MAR_mem_read(MAR_mem_read),
    .MEM_RW(MEM_RW), .MEM_EN(MEM_EN), .MDR_mem_write(MDR_mem_write),
    .MDR_write(MDR_write), .MDR_read(MDR_read), .busy(busy), .err(err)
  );

  assign all_out = {gnt_if, gnt_ls, done_if, done_ls, addr_sel, MAR_write, MAR_mem_read,
                    MEM_RW, MEM_EN, MDR_mem_write, MDR_write, MDR_read, busy, err};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- request / memory driver ----------------
  always @(negedge clk) begin
    if (reset) begin
      rem = -1;
      MFC = 1'b1;
    end else begin
      if (done_if && if_left > 0) if_left--;
      if (done_ls && ls_left > 0) begin
        ls_left--;
        if (lsrw_q.size() > 0) lsrw_q.delete(0);
      end
      if (drop_ls && gnt_ls && MEM_EN && ls_left == 1) ls_dropped = 1;
      if (gnt_ls && !done_ls) ls_rw = 1'($urandom_range(0, 1));
      else ls_rw = (lsrw_q.size() > 0) ? lsrw_q[0] : 1'b0;
      // MFC value set here is sampled by the DUT at the following WAIT edge.
      if (MEM_EN) begin
        rem = (mfc_q.size() > 0) ? mfc_q.pop_front() : 0;
        MFC = 1'b1;
      end else if (rem >= 0) begin
        MFC = (rem == 0) ? 1'b0 : 1'b1;
        rem--;
      end else begin
        MFC = 1'b1;
      end
    end
    req_if = (if_left > 0);
    req_ls = (ls_left > 0) && !ls_dropped;
  end

  // ---------------- monitor / scoreboard ----------------
  bit          in_txn = 0;
  bit          prev_done = 0;
  logic        m_ls, rw_seen, mdrw_seen, asel_seen;
  int          lat, cap;
  logic [10:0] e;

  always @(negedge clk) begin
    if (reset) begin
      in_txn    = 0;
      prev_done = 0;
    end else begin
      check("gnt_excl", 32'(gnt_if & gnt_ls), 0);
      check("busy_vs_gnt", 32'(busy), 32'(gnt_if | gnt_ls));
      check("done_no_gnt", 32'((done_if | done_ls) & !(gnt_if | gnt_ls)), 0);
      if (prev_done) check("idle_gap", 32'(busy), 0);
      if (gnt_if | gnt_ls) begin
        if (!in_txn) begin
          in_txn    = 1;
          m_ls      = gnt_ls;
          lat       = 0;
          cap       = 0;
          rw_seen   = 1'bx;
          mdrw_seen = MDR_write;
          asel_seen = addr_sel;
          check("addr_mar_write", 32'(MAR_write), 1);
        end else begin
          check("mdr_write_outside_addr", 32'(MDR_write), 0);
          if (gnt_ls !== m_ls) check("gnt_stable", 32'(gnt_ls), 32'(m_ls));
        end
        lat++;
        if (MEM_EN) rw_seen = MEM_RW;
        if (MDR_mem_write) cap++;
        if (done_if | done_ls) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("done_ls", 32'(done_ls), 32'(e[10]));
            check("done_if", 32'(done_if), 32'(!e[10]));
            check("addr_sel", 32'(asel_seen), 32'(e[10]));
            check("mem_rw", 32'(rw_seen), 32'(e[9]));
            check("latency", lat, 32'(e[7:0]));
            check("capture_count", cap, 32'(e[9] & !e[8]));
            check("mdr_write", 32'(mdrw_seen), 32'(!e[9]));
            check("mdr_read", 32'(MDR_read), 32'(e[9] & !e[8]));
            check("err", 32'(err), 32'(e[8]));
          end
          in_txn = 0;
        end
      end
      prev_done = done_if | done_ls;
    end
  end

  // ---------------- stimulus ----------------
  // Reference ordering: with both pending, the requester not served last wins.
  task automatic plan(int nif, int nls, bit drop, int fix_n, int fix_rw);
    int a;
    int b;
    int n;
    bit ls;
    bit rw;
    a = nif;
    b = nls;
    while (a > 0 || b > 0) begin
      ls = (a > 0 && b > 0) ? !last_ls : (b > 0);
      last_ls = ls;
      if (!ls) rw = 1'b1;
      else if (fix_rw >= 0) rw = fix_rw[0];
      else rw = 1'($urandom_range(0, 1));
      n = (fix_n >= 0) ? fix_n : int'($urandom_range(0, 3));
      if (ls) lsrw_q.push_back(rw);
      mfc_q.push_back(n);
      exp_q.push_back({ls, rw, 1'b0, 8'(n + 4 + int'(rw))});
      if (ls) b--;
      else a--;
    end
    drop_ls    = drop;
    ls_dropped = 0;
    if_left    = nif;
    ls_left    = nls;
  endtask

  task automatic clear_env();
    exp_q.delete();
    mfc_q.delete();
    lsrw_q.delete();
    if_left    = 0;
    ls_left    = 0;
    drop_ls    = 0;
    ls_dropped = 0;
    last_ls    = 1;
  endtask

  task automatic recover();
    reset = 1'b1;
    @(posedge clk); #1;
    clear_env();
    @(posedge clk); #3;
    reset = 1'b0;
  endtask

  task automatic wait_done(string name);
    int c;
    for (c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (if_left == 0 && ls_left == 0 && !busy) break;
    end
    check({name, "_timeout"}, 32'(c >= 400), 0);
    check({name, "_exp_left"}, exp_q.size(), 0);
    if (c >= 400) recover();
  endtask

  initial begin
    int c;
    bit ok;
    int nif;
    int nls;
    reset = 1'b1;
    req_if = 1'b0;
    req_ls = 1'b0;
    ls_rw = 1'b0;
    MFC = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(all_out), 0);
    #2 reset = 1'b0;

    plan(1, 0, 0, 0, -1);  wait_done("if_read");
    plan(0, 1, 0, 3, 0);   wait_done("ls_write_wait");
    plan(0, 1, 0, 0, 1);   wait_done("ls_read");
    plan(2, 2, 0, -1, -1); wait_done("alternate");
    plan(0, 1, 1, 1, 1);   wait_done("ls_drop");

    // Reset during WAIT of an LS read.
    plan(0, 1, 0, 20, 1);
    for (c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (MEM_EN) break;
    end
    check("reset_test_reach_access", 32'(c >= 50), 0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("reset_mid_txn", 32'(all_out), 0);
    @(posedge clk); #1;
    clear_env();
    plan(1, 1, 0, -1, -1);
    @(posedge clk); #3;
    reset = 1'b0;
    wait_done("post_reset_if_first");

    // Memory never completes.
`ifdef MEM_TIMEOUT_EN
    mfc_q.push_back(1000);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 8'd7});
    last_ls = 0;
    if_left = 1;
    wait_done("timeout_abort");
`else
    mfc_q.push_back(1000);
    if_left = 1;
    repeat (3) @(posedge clk);
    #1;
    ok = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!busy || done_if) ok = 0;
    end
    check("stuck_wait_busy", 32'(ok), 1);
    recover();
`endif

    for (int r = 0; r < 25; r++) begin
      nif = $urandom_range(0, 3);
      nls = $urandom_range(0, 3);
      if (nif == 0 && nls == 0) nif = 1;
      plan(nif, nls, (nls > 0) && ($urandom_range(0, 3) == 0), -1, -1);
      wait_done("random_round");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
